pixel_axi_writer: RTL and testbench

- Downstream stage of the pixel data formatter in the JPEG decoder writeback path.
- Consumes the formatter's 32-bit packed word stream and writes it to memory as AXI4 INCR write bursts.
- Bursts never cross a 4 KB boundary.
- Write data may be presented before the matching AW handshake completes; write responses are tracked with a bounded outstanding count.

---
 rtl/pixel_axi_pkg.sv | 16 +
 rtl/pixel_burst_len_fifo.sv | 51 +++++
 rtl/pixel_axi_writer.sv | 168 ++++++++++++++++
 tb/tb_pixel_axi_writer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_axi_pkg.sv
// Shared constants and FSM state type for the pixel AXI writeback writer.
package pixel_axi_pkg;

  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned PAGE_BYTES     = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_WAIT_B
  } wr_state_e;

endpackage

// File: rtl/pixel_burst_len_fifo.sv
// Small synchronous FIFO holding the beat count of each issued burst for the W path.
module pixel_burst_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pixel_axi_writer.sv
// Writes the formatter's 32-bit word stream to memory as 4 KB-safe AXI4 INCR bursts.
module pixel_axi_writer
  import pixel_axi_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [23:0]       total_words_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic [31:0]       data_i,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [7:0]        awlen_o,
  output logic [2:0]        awsize_o,
  output logic [1:0]        awburst_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  output logic [31:0]       wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wlast_o,
  input  logic              bvalid_i,
  output logic              bready_o,
  input  logic [1:0]        bresp_i
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       remaining_q;
  logic [8:0]        len_q, len_calc;
  logic [10:0]       page_words;
  logic [OW-1:0]     outstanding_q;
  logic [7:0]        beat_q;
  logic [8:0]        head_len;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              start_acc, aw_fire, done_d;
  logic              w_active, w_fire;

  assign awsize_o  = AXI_SIZE_4B;
  assign awburst_o = AXI_BURST_INCR;
  assign wstrb_o   = 4'hF;
  assign bready_o  = 1'b1;
  assign awaddr_o  = addr_q;
  assign awlen_o   = 8'(len_q - 9'd1);

  // Burst length: smallest of MAX_BURST, words left, and words left in the 4 KB page.
  always_comb begin
    page_words = 11'(PAGE_BYTES / 4) - {1'b0, addr_q[11:2]};
    len_calc   = 9'(MAX_BURST);
    if (remaining_q < 24'(len_calc)) len_calc = remaining_q[8:0];
    if (page_words < 11'(len_calc))  len_calc = page_words[8:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    fifo_push = 1'b0;
    aw_fire   = 1'b0;
    awvalid_o = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = (total_words_i == '0) ? ST_WAIT_B : ST_CALC;
        end
      end
      ST_CALC: begin
        if (!fifo_full && (outstanding_q < OW'(MAX_OUTSTANDING))) begin
          fifo_push = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        awvalid_o = 1'b1;
        if (awready_i) begin
          aw_fire = 1'b1;
          state_d = (remaining_q == 24'(len_q)) ? ST_WAIT_B : ST_CALC;
        end
      end
      ST_WAIT_B: begin
        if ((outstanding_q == '0) && fifo_empty) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      remaining_q   <= '0;
      len_q         <= '0;
      outstanding_q <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      done_o <= done_d;
      if (start_acc) begin
        addr_q      <= base_addr_i & ~ADDR_W'(3);
        remaining_q <= total_words_i;
        err_o       <= 1'b0;
        busy_o      <= 1'b1;
      end
      if (done_d) busy_o <= 1'b0;
      if (fifo_push) len_q <= len_calc;
      if (aw_fire) begin
        addr_q      <= addr_q + (ADDR_W'(len_q) << 2);
        remaining_q <= remaining_q - 24'(len_q);
      end
      unique case ({aw_fire, bvalid_i})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - OW'(1);
        default: ;
      endcase
      if (bvalid_i && (bresp_i != AXI_RESP_OKAY)) err_o <= 1'b1;
    end
  end

  // W side runs off the length FIFO alone, so data may lead its AW handshake.
  assign w_active     = ~fifo_empty;
  assign wvalid_o     = data_valid_i & w_active;
  assign data_ready_o = wready_i & w_active;
  assign wdata_o      = data_i;
  assign w_fire       = data_valid_i & wready_i & w_active;
  assign wlast_o      = w_active & ({1'b0, beat_q} == (head_len - 9'd1));
  assign fifo_pop     = w_fire & wlast_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        beat_q <= '0;
    else if (fifo_pop) beat_q <= '0;
    else if (w_fire)   beat_q <= beat_q + 8'(1);
  end

  pixel_burst_len_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(9)
  ) u_len_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (len_calc),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (head_len)
  );

endmodule

// File: tb/tb_pixel_axi_writer.sv
// Self-checking bench for pixel_axi_writer: directed plus randomized jobs against a burst-list model.
module tb_pixel_axi_writer;

  localparam int ADDR_W  = 32;
  localparam int MAX_BURST = 16;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [23:0]       total_words_i = '0;
  logic              busy_o, done_o, err_o;
  logic              data_valid_i = 1'b0;
  logic              data_ready_o;
  logic [31:0]       data_i = '0;
  logic              awvalid_o;
  logic              awready_i = 1'b0;
  logic [ADDR_W-1:0] awaddr_o;
  logic [7:0]        awlen_o;
  logic [2:0]        awsize_o;
  logic [1:0]        awburst_o;
  logic              wvalid_o;
  logic              wready_i = 1'b0;
  logic [31:0]       wdata_o;
  logic [3:0]        wstrb_o;
  logic              wlast_o;
  logic              bvalid_i = 1'b0;
  logic              bready_o;
  logic [1:0]        bresp_i = 2'b00;

  always #5 clk = ~clk;

  pixel_axi_writer #(
    .ADDR_W(ADDR_W),
    .MAX_BURST(MAX_BURST),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .total_words_i(total_words_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
    .awsize_o(awsize_o), .awburst_o(awburst_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .bvalid_i(bvalid_i),
    .bready_o(bready_o), .bresp_i(bresp_i)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    assert (got === exp) else begin
      bad_cnt++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed traffic and slave bookkeeping
  logic [39:0] aw_q[$];
  int          wlast_q[$];
  int          wbeats, wlast_cnt, done_cnt, b_cnt, b_at_done, b_sent;
  int          w_bad, aw_bad, err_track_bad;
  bit          err_model, err_track_on, up_hs_flag, aw_prev_pending;
  logic [39:0] aw_prev;

  // Slave / upstream behaviour knobs
  bit rand_valid, rand_ready, aw_block, b_hold;
  int err_burst;

  // Expected burst list from the model
  logic [39:0] exp_aw[$];
  int          exp_last[$];
  int unsigned exp_words;

  task automatic clear_mon();
    aw_q.delete(); wlast_q.delete();
    wbeats = 0; wlast_cnt = 0; done_cnt = 0; b_cnt = 0; b_at_done = -1; b_sent = 0;
    w_bad = 0; aw_bad = 0; err_track_bad = 0;
    err_model = 1'b0; aw_prev_pending = 1'b0;
  endtask

  // Monitor: samples on the falling edge what the next rising edge will commit.
  initial forever begin
    bit up_hs, w_hs;
    @(negedge clk);
    if (rst_n) begin
      if (awvalid_o) begin
        if (aw_prev_pending && ({awaddr_o, awlen_o} !== aw_prev)) aw_bad++;
        if (awsize_o !== 3'b010 || awburst_o !== 2'b01) aw_bad++;
        aw_prev = {awaddr_o, awlen_o};
        aw_prev_pending = !awready_i;
        if (awready_i) aw_q.push_back({awaddr_o, awlen_o});
      end else begin
        if (aw_prev_pending) aw_bad++;
        aw_prev_pending = 1'b0;
      end
      up_hs = data_valid_i && data_ready_o;
      w_hs  = wvalid_o && wready_i;
      up_hs_flag = up_hs;
      if ((up_hs != w_hs) || (w_hs && (wdata_o !== data_i || wstrb_o !== 4'hF))) w_bad++;
      if (bready_o !== 1'b1) w_bad++;
      if (w_hs) begin
        wbeats++;
        if (wlast_o) begin
          wlast_q.push_back(wbeats);
          wlast_cnt++;
        end
      end
      if (done_o) begin
        done_cnt++;
        b_at_done = b_cnt;
      end
      if (err_track_on && (err_o !== err_model)) err_track_bad++;
      if (bvalid_i) begin
        b_cnt++;
        if (bresp_i != 2'b00) err_model = 1'b1;
      end
    end
  end

  // Upstream source and AXI slave, driven just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (up_hs_flag) data_i = $urandom;
    data_valid_i = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
    wready_i     = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    awready_i    = aw_block ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    bvalid_i     = 1'b0;
    bresp_i      = 2'b00;
    if (!b_hold && (b_sent < aw_q.size()) && (b_sent < wlast_cnt) &&
        (!rand_ready || ($urandom_range(0, 1) != 0))) begin
      b_sent++;
      bvalid_i = 1'b1;
      bresp_i  = (b_sent == err_burst) ? 2'b10 : 2'b00;
    end
  end

  task automatic start_job(input logic [31:0] base, input int unsigned words, input int errb);
    int unsigned a, rem, len, room, cum;
    exp_aw.delete(); exp_last.delete();
    a = base & ~32'd3; rem = words; cum = 0;
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 4;
      len  = MAX_BURST;
      if (rem < len)  len = rem;
      if (room < len) len = room;
      exp_aw.push_back({a, 8'(len - 1)});
      cum += len;
      exp_last.push_back(int'(cum));
      a   += len * 4;
      rem -= len;
    end
    exp_words = words;
    @(posedge clk); #2;
    clear_mon();
    err_burst     = errb;
    start_i       = 1'b1;
    base_addr_i   = base;
    total_words_i = 24'(words);
    @(posedge clk); #2;
    start_i      = 1'b0;
    err_model    = 1'b0;
    err_track_on = 1'b1;
  endtask

  task automatic finish_job(input string tag);
    int n;
    bit exp_err;
    @(negedge clk);
    check({tag, " busy"}, 64'(busy_o), 64'd1);
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != 0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check({tag, " done_once"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_clr"}, 64'(busy_o), 64'd0);
    check({tag, " aw_count"}, 64'(aw_q.size()), 64'(exp_aw.size()));
    n = (aw_q.size() < exp_aw.size()) ? aw_q.size() : exp_aw.size();
    for (int i = 0; i < n; i++) check($sformatf("%s aw%0d", tag, i), 64'(aw_q[i]), 64'(exp_aw[i]));
    check({tag, " wbeats"}, 64'(wbeats), 64'(exp_words));
    check({tag, " wlast_count"}, 64'(wlast_q.size()), 64'(exp_last.size()));
    n = (wlast_q.size() < exp_last.size()) ? wlast_q.size() : exp_last.size();
    for (int i = 0; i < n; i++) check($sformatf("%s wlast%0d", tag, i), 64'(wlast_q[i]), 64'(exp_last[i]));
    check({tag, " wdata"}, 64'(w_bad), 64'd0);
    check({tag, " aw_proto"}, 64'(aw_bad), 64'd0);
    check({tag, " b_at_done"}, 64'(b_at_done), 64'(exp_aw.size()));
    exp_err = (err_burst >= 1) && (err_burst <= exp_aw.size());
    check({tag, " err"}, 64'(err_o), 64'(exp_err));
    check({tag, " err_track"}, 64'(err_track_bad), 64'd0);
    err_track_on = 1'b0;
  endtask

  initial begin
    int k;
    int unsigned r;
    logic [31:0] base;
    clear_mon();
    err_track_on = 1'b0; up_hs_flag = 1'b0;
    rand_valid = 1'b0; rand_ready = 1'b0; aw_block = 1'b0; b_hold = 1'b0; err_burst = 0;
    data_i = $urandom;
    repeat (3) @(negedge clk);
    check("rst awvalid", 64'(awvalid_o), 64'd0);
    check("rst wvalid", 64'(wvalid_o), 64'd0);
    check("rst data_ready", 64'(data_ready_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst done", 64'(done_o), 64'd0);
    check("rst err", 64'(err_o), 64'd0);
    check("rst bready", 64'(bready_o), 64'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three bursts, aligned base, everything ready
    start_job(32'h0000_1000, 40, 0);
    finish_job("basic");

    // Start just below a 4 KB boundary
    start_job(32'h0000_0FF0, 8, 0);
    finish_job("page");

    // W data ahead of a stalled AW
    aw_block = 1'b1;
    start_job(32'h0000_2000, 16, 0);
    repeat (30) @(negedge clk);
    check("awstall wbeats", 64'(wbeats), 64'd16);
    check("awstall wlast", 64'(wlast_q.size()), 64'd1);
    check("awstall no_aw", 64'(aw_q.size()), 64'd0);
    check("awstall awvalid", 64'(awvalid_o), 64'd1);
    aw_block = 1'b0;
    finish_job("awstall");

    // Outstanding limit with B withheld
    b_hold = 1'b1;
    start_job(32'h0000_0000, 100, 0);
    repeat (80) @(negedge clk);
    check("outst aw_count", 64'(aw_q.size()), 64'(MAX_OUT));
    check("outst awvalid", 64'(awvalid_o), 64'd0);
    check("outst no_done", 64'(done_cnt), 64'd0);
    b_hold = 1'b0;
    finish_job("outst");

    // Error response on the middle burst
    start_job(32'h0000_1000, 40, 2);
    finish_job("err");

    // Randomized jobs; the first also confirms err is cleared by the next start
    rand_valid = 1'b1; rand_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      r = $urandom;
      base = (j % 2 == 0) ? r : ((r & 32'hFFFF_F000) | (32'd4096 - 32'd4 * 32'($urandom_range(1, 20))));
      start_job(base, $urandom_range(1, 70), (j == 3) ? 1 : 0);
      finish_job($sformatf("rand%0d", j));
    end
    rand_valid = 1'b0; rand_ready = 1'b0;

    // Zero-length job
    start_job(32'h0000_4000, 0, 0);
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done_o) break;
    end
    check("zero done_latency", 64'(k), 64'd2);
    repeat (3) @(negedge clk);
    check("zero done_once", 64'(done_cnt), 64'd1);
    check("zero no_aw", 64'(aw_q.size()), 64'd0);
    check("zero no_w", 64'(wbeats), 64'd0);
    err_track_on = 1'b0;

    // Asynchronous reset in the middle of a burst
    start_job(32'h0000_5000, 40, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wvalid_o) break;
    end
    check("midrst saw_w", 64'(wvalid_o), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst awvalid", 64'(awvalid_o), 64'd0);
    check("midrst wvalid", 64'(wvalid_o), 64'd0);
    check("midrst data_ready", 64'(data_ready_o), 64'd0);
    check("midrst busy", 64'(busy_o), 64'd0);
    err_track_on = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst idle_aw", 64'(aw_q.size()), 64'd0);
    check("midrst idle_busy", 64'(busy_o), 64'd0);
    start_job(32'h0000_3000, 5, 0);
    finish_job("postrst");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
